// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned PKG_WIDTH  = 32;
  localparam int unsigned PKG_INST_W = INST_BYTES * 8;

  typedef logic [2:0] ifu_state_t;

  localparam ifu_state_t S_IDLE = 3'd0;
  localparam ifu_state_t S_REQ  = 3'd1;
  localparam ifu_state_t S_WAIT = 3'd2;
  localparam ifu_state_t S_DROP = 3'd3;
  localparam ifu_state_t S_HALT = 3'd4;

  typedef struct packed {
    logic [PKG_INST_W-1:0] inst;
    logic [PKG_WIDTH-1:0]  pc;
    logic                  err;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// Circular FIFO of fetch entries with synchronous flush; the head is read combinationally.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  entry_t                 i_push_data,
  input  logic                   i_pop,
  output entry_t                 o_head,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
  assign w_do_push = i_push && !i_flush && ((r_count != FULL) || w_do_pop);

  // Array is reset so an empty queue never presents X on the head fields.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: single-outstanding fetch FSM feeding a small queue,
// with redirect flushing queued and in-flight instructions.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned       WIDTH    = PKG_WIDTH,
  parameter int unsigned       INST_W   = PKG_INST_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WIDTH-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_redirect_valid,
  input  logic [WIDTH-1:0]       i_redirect_pc,
  output logic                   o_mem_req_valid,
  output logic [WIDTH-1:0]       o_mem_req_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_resp_valid,
  input  logic [INST_W-1:0]      i_mem_resp_data,
  input  logic                   i_mem_resp_err,
  output logic                   o_ifu_valid,
  output logic [INST_W-1:0]      o_ifu_inst,
  output logic [WIDTH-1:0]       o_ifu_pc,
  output logic                   o_ifu_err,
  input  logic                   i_idu_ready,
  output logic [$clog2(DEPTH):0] o_ifu_count
);

  localparam int unsigned        CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]   FULL    = CNT_W'(DEPTH);
  localparam logic [WIDTH-1:0]   PC_STEP = WIDTH'(INST_W / 8);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [WIDTH-1:0]  pc;
    logic              err;
  } entry_t;

  ifu_state_t       r_state, w_state_d;
  logic [WIDTH-1:0] r_fetch_pc, w_fetch_pc_d;
  logic [WIDTH-1:0] r_req_addr, w_req_addr_d;
  logic             r_stale, w_stale_d;
  logic             w_push;
  logic [CNT_W-1:0] w_count;
  entry_t           w_push_data;
  entry_t           w_head;

  always_comb begin
    w_state_d    = r_state;
    w_fetch_pc_d = r_fetch_pc;
    w_req_addr_d = r_req_addr;
    w_stale_d    = r_stale;
    w_push       = 1'b0;
    if (i_redirect_valid) w_fetch_pc_d = i_redirect_pc;
    unique case (r_state)
      S_IDLE: begin
        // The single outstanding fetch reserves its slot here, so a push never overflows.
        if (!i_redirect_valid && (w_count < FULL)) begin
          w_state_d    = S_REQ;
          w_req_addr_d = r_fetch_pc;
        end
      end
      S_REQ: begin
        // The address stays on the old PC until accepted; a redirect just dooms the fetch.
        if (i_mem_req_ready) begin
          w_state_d = (r_stale || i_redirect_valid) ? S_DROP : S_WAIT;
          w_stale_d = 1'b0;
        end else if (i_redirect_valid) begin
          w_stale_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_redirect_valid) begin
          w_state_d = i_mem_resp_valid ? S_IDLE : S_DROP;
        end else if (i_mem_resp_valid) begin
          w_push       = 1'b1;
          w_fetch_pc_d = r_fetch_pc + PC_STEP;
          w_state_d    = i_mem_resp_err ? S_HALT : S_IDLE;
        end
      end
      S_DROP: begin
        if (i_mem_resp_valid) w_state_d = S_IDLE;
      end
      S_HALT: begin
        if (i_redirect_valid) w_state_d = S_IDLE;
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_stale    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_fetch_pc <= w_fetch_pc_d;
      r_req_addr <= w_req_addr_d;
      r_stale    <= w_stale_d;
    end
  end

  assign w_push_data = '{inst: i_mem_resp_data, pc: r_req_addr, err: i_mem_resp_err};

  ifu_fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (i_idu_ready),
    .o_head      (w_head),
    .o_valid     (o_ifu_valid),
    .o_count     (w_count)
  );

  assign o_mem_req_valid = (r_state == S_REQ);
  assign o_mem_req_addr  = r_req_addr;
  assign o_ifu_inst      = w_head.inst;
  assign o_ifu_pc        = w_head.pc;
  assign o_ifu_err       = w_head.err;
  assign o_ifu_count     = w_count;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: random memory/IDU/redirect traffic checked against a
// transaction-level model of fetch order, flushing and fault halting.
module tb_ifu_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        ifu_valid;
  logic [31:0] ifu_inst;
  logic [31:0] ifu_pc;
  logic        ifu_err;
  logic        idu_ready;
  logic [2:0]  ifu_count;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .WIDTH    (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_mem_req_valid  (mem_req_valid),
    .o_mem_req_addr   (mem_req_addr),
    .i_mem_req_ready  (mem_req_ready),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_resp_data  (mem_resp_data),
    .i_mem_resp_err   (mem_resp_err),
    .o_ifu_valid      (ifu_valid),
    .o_ifu_inst       (ifu_inst),
    .o_ifu_pc         (ifu_pc),
    .o_ifu_err        (ifu_err),
    .i_idu_ready      (idu_ready),
    .o_ifu_count      (ifu_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected queue holds {err, pc, inst}.
  logic [64:0] exp_q[$];
  logic [31:0] next_pc;
  bit          halted;
  bit          req_open, req_doomed;
  logic [31:0] req_addr;
  bit          busy, busy_doomed;
  logic [31:0] busy_addr;
  int          lat_left;
  int          idle_cnt, cyc, err_pops;
  logic [31:0] req_log[$];
  int          req_cyc[$];

  int          ready_pct, idu_pct, redir_pct, err_pct, min_lat, max_lat;
  logic [31:0] err_addr;
  bit          force_redir, spurious_resp;
  logic [31:0] force_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [64:0] log_at(input int i);
    if (i < req_log.size()) return 65'(req_log[i]);
    return 'x;
  endfunction

  function automatic int cyc_gap(input int i);
    if (i + 1 < req_cyc.size()) return req_cyc[i+1] - req_cyc[i];
    return -1;
  endfunction

  function automatic bit roll(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  task automatic step();
    bit          redir, pop, push;
    logic [64:0] new_e;
    new_e = '0;
    check("count", 65'(ifu_count), 65'(exp_q.size()));
    check("valid", 65'(ifu_valid), 65'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("head", {ifu_err, ifu_pc, ifu_inst}, exp_q[0]);
    if (mem_req_valid && !req_open) begin
      check("req_addr", 65'(mem_req_addr), 65'(next_pc));
      check("req_gate", 65'(halted || busy || exp_q.size() >= DEPTH), 65'(0));
      req_open   = 1'b1;
      req_addr   = mem_req_addr;
      req_doomed = 1'b0;
      req_log.push_back(mem_req_addr);
      req_cyc.push_back(cyc);
    end else if (req_open) begin
      check("req_hold_valid", 65'(mem_req_valid), 65'(1));
      check("req_hold_addr", 65'(mem_req_addr), 65'(req_addr));
    end
    if (!mem_req_valid && !req_open && !busy && !halted && exp_q.size() < DEPTH) idle_cnt++;
    else idle_cnt = 0;
    check("issue_stall", 65'(idle_cnt > 3), 65'(0));

    redir          = force_redir || roll(redir_pct);
    redirect_valid = redir;
    redirect_pc    = force_redir ? force_pc : ($urandom & 32'hFFFF_FFFC);
    force_redir    = 1'b0;
    mem_req_ready  = roll(ready_pct);
    idu_ready      = roll(idu_pct);
    if (busy && lat_left == 0) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = inst_of(busy_addr);
      mem_resp_err   = (busy_addr == err_addr) || roll(err_pct);
    end else begin
      mem_resp_valid = spurious_resp;
      mem_resp_data  = $urandom;
      mem_resp_err   = 1'($urandom_range(1, 0));
    end
    spurious_resp = 1'b0;

    pop  = (exp_q.size() != 0) && idu_ready && !redir;
    push = 1'b0;
    if (busy && mem_resp_valid) begin
      busy = 1'b0;
      if (!busy_doomed && !redir) begin
        push    = 1'b1;
        new_e   = {mem_resp_err, busy_addr, mem_resp_data};
        next_pc = busy_addr + 32'd4;
        if (mem_resp_err) halted = 1'b1;
      end
    end else if (busy) begin
      if (redir) busy_doomed = 1'b1;
      lat_left--;
    end
    if (req_open && mem_req_ready) begin
      busy        = 1'b1;
      busy_addr   = req_addr;
      busy_doomed = req_doomed || redir;
      lat_left    = int'($urandom_range(max_lat, min_lat));
      req_open    = 1'b0;
    end else if (req_open && redir) begin
      req_doomed = 1'b1;
    end
    if (redir) begin
      exp_q.delete();
      next_pc  = redirect_pc;
      halted   = 1'b0;
      idle_cnt = 0;
    end else begin
      if (pop) begin
        if (exp_q[0][64]) err_pops++;
        void'(exp_q.pop_front());
      end
      if (push) begin
        check("no_overflow", 65'(exp_q.size() < DEPTH), 65'(1));
        exp_q.push_back(new_e);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic reset_dut();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
    idu_ready      = 1'b0;
    #1;
    check("rst_req_valid", 65'(mem_req_valid), 65'(0));
    check("rst_ifu_valid", 65'(ifu_valid), 65'(0));
    check("rst_count", 65'(ifu_count), 65'(0));
    check("rst_head", {ifu_err, ifu_pc, ifu_inst}, 65'(0));
    exp_q.delete();
    next_pc  = RESET_PC;
    halted   = 1'b0;
    req_open = 1'b0;
    busy     = 1'b0;
    idle_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0; idu_ready = 1'b0;
    force_redir = 1'b0; spurious_resp = 1'b0; force_pc = '0;
    cyc = 0; err_pops = 0;
    ready_pct = 100; idu_pct = 100; redir_pct = 0; err_pct = 0;
    min_lat = 0; max_lat = 0; err_addr = 32'h1;
    #2;

    // Sequential fetch from reset, best-case cadence.
    reset_dut();
    run(12);
    check("p1_addr0", log_at(0), 65'(32'h8000_0000));
    check("p1_addr1", log_at(1), 65'(32'h8000_0004));
    check("p1_addr2", log_at(2), 65'(32'h8000_0008));
    check("p1_gap0", 65'(cyc_gap(0)), 65'(3));
    check("p1_gap1", 65'(cyc_gap(1)), 65'(3));

    // Backpressure: queue fills to DEPTH and fetching stops.
    idu_pct = 0;
    run(20);
    check("bp_count", 65'(ifu_count), 65'(DEPTH));
    check("bp_req_valid", 65'(mem_req_valid), 65'(0));
    req_log.delete();
    idu_pct = 100;
    run(20);
    check("bp_resume", 65'(req_log.size() > 2), 65'(1));

    // Redirect while waiting on a slow response.
    min_lat = 3; max_lat = 3;
    for (int i = 0; i < 20 && !(busy && !busy_doomed); i++) step();
    check("p3_sync", 65'(busy), 65'(1));
    force_redir = 1'b1; force_pc = 32'h8000_1000;
    step();
    req_log.delete();
    run(15);
    check("p3_next", log_at(0), 65'(32'h8000_1000));

    // Redirect while the request is stalled on ready.
    min_lat = 0; max_lat = 0; ready_pct = 0;
    for (int i = 0; i < 20 && !req_open; i++) step();
    check("p4_sync", 65'(req_open), 65'(1));
    force_redir = 1'b1; force_pc = 32'h8000_2000;
    step();
    step();
    ready_pct = 100;
    req_log.delete();
    run(12);
    check("p4_next", log_at(0), 65'(32'h8000_2000));

    // Access fault halts fetching until redirected.
    err_addr = 32'h8000_0008;
    force_redir = 1'b1; force_pc = 32'h8000_0000;
    step();
    req_log.delete(); err_pops = 0;
    run(20);
    check("p5_err_delivered", 65'(err_pops), 65'(1));
    check("p5_req_count", 65'(req_log.size()), 65'(3));
    check("p5_halt_noreq", 65'(mem_req_valid), 65'(0));
    err_addr = 32'h1;
    force_redir = 1'b1; force_pc = 32'h8000_0100;
    step();
    req_log.delete();
    run(10);
    check("p5_restart", log_at(0), 65'(32'h8000_0100));

    // PC wrap.
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
    step();
    req_log.delete();
    run(12);
    check("p6_top", log_at(0), 65'(32'hFFFF_FFFC));
    check("p6_wrap", log_at(1), 65'(32'h0000_0000));

    // Reset in the middle of a fetch; a stray response after release is ignored.
    min_lat = 3; max_lat = 3;
    for (int i = 0; i < 20 && !busy; i++) step();
    check("p7_sync", 65'(busy), 65'(1));
    reset_dut();
    spurious_resp = 1'b1;
    req_log.delete();
    run(10);
    check("p7_first", log_at(0), 65'(RESET_PC));

    // Random traffic.
    redir_pct = 3; err_pct = 5; min_lat = 0; max_lat = 3;
    for (int k = 0; k < 8; k++) begin
      idu_pct   = (k % 3 == 0) ? 15 : ((k % 3 == 1) ? 60 : 100);
      ready_pct = (k % 2 == 0) ? 70 : 40;
      run(500);
    end
    redir_pct = 0; err_pct = 0; idu_pct = 100; ready_pct = 100;
    force_redir = 1'b1; force_pc = 32'h8000_4000;
    step();
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
